mdu_ctrl: RTL and testbench
===========================

# mdu_ctrl

Multi-cycle sequencer for the RV32M multiply/divide/remainder unit in the execute stage. It accepts one M-extension instruction at a time (opcode R, funct7 = 0000001) from the EX stage. It runs a registered multiply or a 32-iteration restoring divide, and holds the pipeline stall line until the result is ready. It returns a single-cycle `done` with the result to the EX output mux, and abandons work on a pipeline flush.

## Interface
Parameters:
- `XLEN`, 32, datapath width; divide iteration count equals XLEN.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  valid M instruction present in EX this cycle.
- `funct3`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a_in`  in  XLEN  rs1 operand.
- `b_in`  in  XLEN  rs2 operand.
- `flush`  in  1  kill any in-flight operation.
- `busy`  out  1  stall request to the hazard unit.
- `done`  out  1  one-cycle pulse; `result` is valid in the same cycle.
- `result`  out  XLEN  registered result; held until the next `done`.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE. On reset: IDLE, `busy`=0, `done`=0, `result`=0, iteration counter 0.
- IDLE with `start` & !`flush`: latch `a_in`, `b_in`, `funct3`. Next state:
  - `funct3`[2]=0: MUL.
  - Divide with `b_in`=0: DONE. DIV/DIVU result 0xFFFFFFFF; REM/REMU result `a_in`.
  - DIV/REM with `a_in`=0x80000000 and `b_in`=0xFFFFFFFF: DONE. DIV result 0x80000000; REM result 0.
  - Otherwise: DIV. Load the operand magnitudes (absolute value for DIV/REM, raw for DIVU/REMU), clear the partial remainder, set counter = XLEN-1.
- MUL: extend both operands to 33 bits. MULH sign-extends both; MULHSU sign-extends a and zero-extends b; MULHU and MUL zero-extend both. Form the 66-bit product. MUL takes bits [31:0]; all others take [63:32]. Next state DONE.
- DIV: one restoring step per cycle.
  - Shift the remainder left, bringing in the dividend MSB.
  - Subtract the divisor magnitude. If the difference is non-negative, keep it and the quotient bit is 1; otherwise restore and the quotient bit is 0.
  - At counter 0 go to FIX, else decrement the counter.
- FIX, signed ops only:
  - Negate the quotient when the operand signs differ.
  - Negate the remainder when the dividend is negative.
  - Load `result` from the quotient or remainder per `funct3`[1]. Next state DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE. `start` in DONE is ignored, because the stalled instruction advances this cycle and the next M instruction arrives the following cycle in IDLE.
- `busy` = (IDLE & `start` & !`flush`) | MUL | DIV | FIX. It is combinational from `start`, so the instruction stalls in its own first cycle. `busy`=0 in DONE.
- `flush`:
  - Has priority over every transition.
  - In any state, the next state is IDLE with no `done`, and `result` is unchanged.
  - `flush` together with `start` in IDLE does not begin an operation.
- Reset asserted mid-operation: immediately return to reset values; no `done`.
- Arithmetic is modulo 2^XLEN. Only the M operations listed above are handled; `funct7` decode is upstream.

## Timing
- Start accepted at edge T (cycle T is `start` high in IDLE).
- Multiply: `done` in cycle T+2. `busy` is high in cycles T and T+1.
- Divide/remainder, normal path: DIV occupies T+1..T+32, FIX T+33, `done` T+34. `busy` is high T..T+33.
- Divide by zero or signed overflow: `done` in cycle T+1. `busy` is high in cycle T only.
- `result` and `done` are registered outputs; `busy` is a combinational output.
- Throughput: one operation per (latency + 1) cycles; back-to-back requests are separated by one IDLE cycle.

## Test plan
- MUL with a=7, b=0xFFFFFFFD -> `result`=0xFFFFFFEB, `done` at T+2, `busy` high for exactly 2 cycles. MULHU with a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU with a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV with a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD at T+34. REM with the same operands -> 0xFFFFFFFF. DIVU with a=100, b=7 -> 14. REMU with the same operands -> 2.
- Divide by zero with a=5, b=0: DIVU -> 0xFFFFFFFF at T+1; REMU -> 5; DIV -> 0xFFFFFFFF.
- Signed overflow with a=0x80000000, b=0xFFFFFFFF: DIV -> 0x80000000 at T+1; REM -> 0.
- Flush at DIV iteration 10 -> `busy` low the next cycle, no `done` pulse, `result` holds its old value. A following DIVU with a=9, b=3 -> 3 with normal latency. `flush` and `start` in the same cycle -> no operation starts.
- Deassert `rst_n` mid-DIV -> all outputs return to 0 asynchronously. After release, a MUL with a=3, b=4 -> 12 at T+2.

Source files
------------

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mdu_ctrl
// Purpose  : Multi-cycle sequencer for the RV32M multiply/divide unit in EX.
//            Runs a registered multiply or a restoring divide (one bit per
//            cycle), stalls the pipeline while working, and pulses done with
//            the result. A flush abandons any in-flight operation.
// Ports    : clk     - clock, rising edge
//            rst_n   - asynchronous active-low reset
//            start   - valid M instruction in EX this cycle
//            funct3  - M-extension operation select
//            a_in    - rs1 operand
//            b_in    - rs2 operand
//            flush   - kill in-flight operation
//            busy    - stall request (combinational)
//            done    - one-cycle completion pulse (registered)
//            result  - registered result, held until the next done
// Revision : 1.0 - initial release
// ============================================================================
module mdu_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a_in,
    input  logic [XLEN-1:0] b_in,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state_q, state_d;
    // a_q holds rs1 for multiply, or the dividend shifting out / quotient
    // shifting in during divide. b_q holds rs2 or the divisor magnitude.
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [1:0]        op_q, op_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              div_signed;
    logic              div_ovf;
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     rem_diff;
    logic              mul_sgn_a;
    logic              mul_sgn_b;
    logic [2*XLEN+1:0] mul_a;
    logic [2*XLEN+1:0] mul_b;
    logic [2*XLEN+1:0] mul_p;
    logic              mul_unused;

    always_comb begin
        div_signed = ~funct3[0];
        div_ovf    = div_signed && (a_in == INT_MIN) && (b_in == '1);

        rem_shift  = {rem_q, a_q[XLEN-1]};
        rem_diff   = rem_shift - {1'b0, b_q};

        // 33-bit operand extension, carried out to the full 66-bit product
        // width so a plain modular multiply yields the signed result.
        mul_sgn_a  = (op_q == 2'b01) || (op_q == 2'b10);
        mul_sgn_b  = (op_q == 2'b01);
        mul_a      = {{(XLEN+2){mul_sgn_a & a_q[XLEN-1]}}, a_q};
        mul_b      = {{(XLEN+2){mul_sgn_b & b_q[XLEN-1]}}, b_q};
        mul_p      = mul_a * mul_b;
        mul_unused = ^mul_p[2*XLEN+1:2*XLEN];

        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        rem_d      = rem_q;
        result_d   = result_q;
        op_d       = op_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        cnt_d      = cnt_q;
        busy       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    busy      = 1'b1;
                    a_d       = a_in;
                    b_d       = b_in;
                    op_d      = funct3[1:0];
                    neg_quo_d = 1'b0;
                    neg_rem_d = 1'b0;
                    if (!funct3[2]) begin
                        state_d = S_MUL;
                    end else if (b_in == '0) begin
                        state_d  = S_DONE;
                        result_d = funct3[1] ? a_in : '1;
                    end else if (div_ovf) begin
                        // DIV yields INT_MIN (equal to a_in here), REM yields 0
                        state_d  = S_DONE;
                        result_d = funct3[1] ? '0 : a_in;
                    end else begin
                        state_d   = S_DIV;
                        a_d       = (div_signed && a_in[XLEN-1]) ? -a_in : a_in;
                        b_d       = (div_signed && b_in[XLEN-1]) ? -b_in : b_in;
                        rem_d     = '0;
                        cnt_d     = CNT_MAX;
                        neg_quo_d = div_signed && (a_in[XLEN-1] ^ b_in[XLEN-1]);
                        neg_rem_d = div_signed && a_in[XLEN-1];
                    end
                end
            end
            S_MUL: begin
                busy     = 1'b1;
                result_d = (op_q == 2'b00) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];
                state_d  = S_DONE;
            end
            S_DIV: begin
                busy = 1'b1;
                // The remainder never exceeds the divisor, so a borrow in
                // the top bit of the difference means "restore".
                if (!rem_diff[XLEN]) begin
                    rem_d = rem_diff[XLEN-1:0];
                    a_d   = {a_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift[XLEN-1:0];
                    a_d   = {a_q[XLEN-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_FIX: begin
                busy = 1'b1;
                if (op_q[1]) begin
                    result_d = neg_rem_q ? -rem_q : rem_q;
                end else begin
                    result_d = neg_quo_q ? -a_q : a_q;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            rem_q     <= '0;
            result_q  <= '0;
            op_q      <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rem_q     <= rem_d;
            result_q  <= result_d;
            op_q      <= op_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            cnt_q     <= cnt_d;
        end
    end

    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_ctrl
// Purpose  : Self-checking bench for mdu_ctrl. Expected results, completion
//            cycles and stall lengths are queued when an operation is issued
//            and compared when done pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_ctrl;

    localparam int XLEN = 32;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    localparam int LAT_MUL = 2;
    localparam int LAT_DIV = 34;
    localparam int LAT_SPC = 1;

    typedef struct {
        string           tag;
        logic [XLEN-1:0] res;
        int              cyc;
        int              busy;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            start = 1'b0;
    logic [2:0]      funct3 = 3'b000;
    logic [XLEN-1:0] a_in = '0;
    logic [XLEN-1:0] b_in = '0;
    logic            flush = 1'b0;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    int              total = 0;
    int              bad = 0;
    int              cyc = 0;
    int              busy_cnt = 0;
    logic [XLEN-1:0] last_exp = '0;
    exp_t            sb[$];

    mdu_ctrl #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .a_in   (a_in),
        .b_in   (b_in),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Output monitor: sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check({e.tag, "_result"}, result, e.res);
                check({e.tag, "_cycle"}, 32'(cyc), 32'(e.cyc));
                check({e.tag, "_busy_cycles"}, 32'(busy_cnt), 32'(e.busy));
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            check("done_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int lat);
        exp_t e;
        @(posedge clk);
        #1;
        busy_cnt = 0;
        start    = 1'b1;
        funct3   = f3;
        a_in     = a;
        b_in     = b;
        e.tag    = tag;
        e.res    = exp;
        e.cyc    = cyc + lat;
        e.busy   = lat;
        sb.push_back(e);
        last_exp = exp;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_drain();
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Multiply family
        run_op("mul",    F_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, LAT_MUL);
        run_op("mulhu",  F_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT_MUL);
        run_op("mulhsu", F_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, LAT_MUL);
        run_op("mulh",   F_MULH,   32'h80000000, 32'h80000000, 32'h40000000, LAT_MUL);

        // Divide family, normal path
        run_op("div_neg",  F_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, LAT_DIV);
        run_op("rem_neg",  F_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LAT_DIV);
        run_op("divu",     F_DIVU, 32'd100,      32'd7,        32'd14,       LAT_DIV);
        run_op("remu",     F_REMU, 32'd100,      32'd7,        32'd2,        LAT_DIV);
        run_op("rem_negb", F_REM,  32'd7,        32'hFFFFFFFE, 32'd1,        LAT_DIV);
        run_op("div_negb", F_DIV,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, LAT_DIV);
        run_op("div_max",  F_DIV,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000001, LAT_DIV);

        // Divide by zero and signed overflow
        run_op("divu_z", F_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, LAT_SPC);
        run_op("remu_z", F_REMU, 32'd5,        32'd0,        32'd5,        LAT_SPC);
        run_op("div_z",  F_DIV,  32'd5,        32'd0,        32'hFFFFFFFF, LAT_SPC);
        run_op("div_ov", F_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT_SPC);
        run_op("rem_ov", F_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,        LAT_SPC);

        // Flush during the tenth divide iteration: no done, result held
        @(posedge clk);
        #1;
        start = 1'b1; funct3 = F_DIVU; a_in = 32'd1000; b_in = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("flush_busy_before", 32'(busy), 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy_after", 32'(busy), 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check("flush_result_hold", result, last_exp);
        run_op("divu_after_flush", F_DIVU, 32'd9, 32'd3, 32'd3, LAT_DIV);

        // Flush together with start: nothing begins
        @(posedge clk);
        #1;
        start = 1'b1; flush = 1'b1; funct3 = F_DIVU; a_in = 32'd50; b_in = 32'd5;
        #1;
        check("flush_start_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy_next", 32'(busy), 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check("flush_start_result_hold", result, last_exp);

        // Asynchronous reset in the middle of a divide
        @(posedge clk);
        #1;
        start = 1'b1; funct3 = F_DIV; a_in = 32'd123; b_in = 32'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("mul_after_rst", F_MUL, 32'd3, 32'd4, 32'd12, LAT_MUL);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
